ex161_ex4511: RTL and testbench

- Demo block: a 74HC161-style 4-bit synchronous binary counter drives a CD4511-style BCD-to-7-segment decoder.
- It gives a free-running counting display for a single common-cathode digit.
- Dn exposes the counter value. Seg drives the display segments.
- Standalone top-level exercise block. No upstream handshake.

---
 rtl/ex161_ex4511.sv | 46 ++++
 tb/tb_ex161_ex4511.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ex161_ex4511.sv
// Free-running 4-bit binary counter driving a BCD-to-7-segment decoder (common cathode).
// Seg follows Dn combinationally (zero latency); no handshake, never stalls; MRN clears asynchronously.
module ex161_ex4511 (
    input  logic       CP,
    input  logic       MRN,
    output logic [3:0] Dn,
    output logic [7:0] Seg
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Count enable is permanently active and load is unused, so every edge increments.
    always_comb begin
        cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            cnt_q <= 4'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Dn = cnt_q;

    // 4511 glyphs: 6 without segment a, 9 without segment d; codes 10..15 blank.
    always_comb begin
        Seg = 8'h00;
        case (cnt_q)
            4'd0:    Seg = 8'h3F;
            4'd1:    Seg = 8'h06;
            4'd2:    Seg = 8'h5B;
            4'd3:    Seg = 8'h4F;
            4'd4:    Seg = 8'h66;
            4'd5:    Seg = 8'h6D;
            4'd6:    Seg = 8'h7C;
            4'd7:    Seg = 8'h07;
            4'd8:    Seg = 8'h7F;
            4'd9:    Seg = 8'h67;
            default: Seg = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ex161_ex4511.sv
`timescale 1ns/1ps
module tb_ex161_ex4511;

    logic       CP  = 1'b0;
    logic       MRN = 1'b1;
    logic [3:0] Dn;
    logic [7:0] Seg;

    int tests = 0;
    int fails = 0;

    // Expected display state per rising edge, consumed by the monitor on the following falling edge.
    int exp_q[$];
    int model_cnt = 0;
    logic [7:0] glyph [16];

    ex161_ex4511 dut (
        .CP  (CP),
        .MRN (MRN),
        .Dn  (Dn),
        .Seg (Seg)
    );

    always #2.5 CP = ~CP;

    function automatic logic [7:0] seg_of(input int v);
        return glyph[v % 16];
    endfunction

    task automatic check(input string name, input logic [3:0] act_dn, input logic [7:0] act_seg,
                         input int exp_v);
        tests++;
        if ((act_dn !== exp_v[3:0]) || (act_seg !== seg_of(exp_v))) begin
            fails++;
            $display("FAIL %s: got Dn=%h Seg=%h, expected Dn=%h Seg=%h",
                     name, act_dn, act_seg, exp_v[3:0], seg_of(exp_v));
        end
    endtask

    // Advance n rising edges; the model counts edges seen with MRN high, modulo 16.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CP);
            if (MRN) model_cnt = (model_cnt + 1) % 16;
            else     model_cnt = 0;
            exp_q.push_back(model_cnt);
        end
    endtask

    // Change MRN between edges (after a falling edge) and verify the asynchronous effect.
    task automatic set_reset(input logic level);
        @(negedge CP);
        #1;
        MRN = level;
        #0.1;
        if (!level) begin
            model_cnt = 0;
            check("async_clear", Dn, Seg, 0);
        end else begin
            check("release_hold", Dn, Seg, model_cnt);
        end
    endtask

    always @(negedge CP) begin
        if (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            check("cycle", Dn, Seg, e);
            tests++;
            if (Seg[7] !== 1'b0) begin
                fails++;
                $display("FAIL dp: got Seg[7]=%b, expected 0", Seg[7]);
            end
        end
    end

    initial begin
        glyph[0] = 8'h3F; glyph[1] = 8'h06; glyph[2] = 8'h5B; glyph[3] = 8'h4F;
        glyph[4] = 8'h66; glyph[5] = 8'h6D; glyph[6] = 8'h7C; glyph[7] = 8'h07;
        glyph[8] = 8'h7F; glyph[9] = 8'h67;
        for (int i = 10; i < 16; i++) glyph[i] = 8'h00;

        // Reset held for 20 ns with the clock running: no increments.
        #0.5;
        MRN = 1'b0;
        #0.1;
        check("reset_state", Dn, Seg, 0);
        step(4);

        // Release, count through the full range, wrap and keep going.
        set_reset(1'b1);
        step(10);
        step(6);
        step(3);

        // Bring the count to 5, then clear mid-cycle and hold in reset.
        step((16 + 5 - model_cnt) % 16);
        set_reset(1'b0);
        step(3);
        set_reset(1'b1);
        step(1);

        // Reset then 32 consecutive edges: 1..15,0 twice.
        set_reset(1'b0);
        step(2);
        set_reset(1'b1);
        step(32);

        // Randomized run lengths and reset pulses.
        for (int k = 0; k < 12; k++) begin
            step($urandom_range(1, 40));
            if ($urandom_range(0, 2) == 0) begin
                set_reset(1'b0);
                step($urandom_range(0, 3));
                set_reset(1'b1);
            end
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CP);
        @(negedge CP);
        #0.1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
